// File: rtl/seq_multiplier_pkg.sv
// Shared types and constants for the digit-serial multiplier and its 2x2 product cell.
// The helper lets the top size its loop without a multiply operator.
package seq_multiplier_pkg;

    localparam int DIGIT_W = 2;
    localparam int PP_W    = DIGIT_W + DIGIT_W;
    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [STATE_W-1:0] ST_BUSY_ENC = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = ST_IDLE_ENC,
        BUSY = ST_BUSY_ENC,
        DONE = ST_DONE_ENC
    } state_e;

    // n squared by repeated addition; only ever evaluated on parameters.
    function automatic int square(input int n);
        int s;
        s = 0;
        for (int k = 0; k < n; k++) begin
            s = s + n;
        end
        return s;
    endfunction

endpackage

// File: rtl/mul2x2_cell.sv
// Combinational unsigned 2x2-bit product cell; result range 0..9.
module mul2x2_cell
    import seq_multiplier_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic [PP_W-1:0]    z
);

    logic [PP_W-1:0] row0;
    logic [PP_W-1:0] row1;

    // Two shifted-and-gated rows of the multiplicand, summed.
    always_comb begin
        row0 = {2'b00, x} & {PP_W{y[0]}};
        row1 = {1'b0, x, 1'b0} & {PP_W{y[1]}};
        z    = row0 + row1;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one 2-bit digit pair per cycle through a
// single 2x2 cell, shifted and accumulated into a 2*WIDTH-bit product.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       x,
    input  logic [WIDTH-1:0]       y,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH+WIDTH-1:0] z
);

    localparam int D      = WIDTH / DIGIT_W;
    localparam int NPAIR  = square(D);
    localparam int PROD_W = WIDTH + WIDTH;
    localparam int CNT_W  = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int IDX_W  = (D > 1) ? $clog2(D) : 1;
    localparam int SH_W   = $clog2(PROD_W);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    xr_q, xr_d;
    logic [WIDTH-1:0]    yr_q, yr_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   z_q, z_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    i_q, i_d;
    logic [IDX_W-1:0]    j_q, j_d;

    logic [DIGIT_W-1:0]  x_dig [D];
    logic [DIGIT_W-1:0]  y_dig [D];
    logic [DIGIT_W-1:0]  x_digit;
    logic [DIGIT_W-1:0]  y_digit;
    logic [PP_W-1:0]     pp;
    logic [SH_W-1:0]     shamt;
    logic [PROD_W-1:0]   pp_shift;
    logic [PROD_W-1:0]   sum;
    logic                last_pair;

    // Split the latched operands into 2-bit digits.
    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_digits
            assign x_dig[gi] = xr_q[(gi << 1) +: DIGIT_W];
            assign y_dig[gi] = yr_q[(gi << 1) +: DIGIT_W];
        end
    endgenerate

    // i walks the x digits (inner loop), j the y digits (outer loop); together they track cnt.
    assign x_digit = x_dig[i_q];
    assign y_digit = y_dig[j_q];

    mul2x2_cell u_cell (
        .x (x_digit),
        .y (y_digit),
        .z (pp)
    );

    assign shamt     = (SH_W'(i_q) + SH_W'(j_q)) << 1;
    assign pp_shift  = PROD_W'(pp) << shamt;
    assign sum       = acc_q + pp_shift;
    assign last_pair = (cnt_q == CNT_W'(NPAIR - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            acc_q   <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (last_pair) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        xr_d  = xr_q;
        yr_d  = yr_q;
        acc_d = acc_q;
        z_d   = z_q;
        cnt_d = cnt_q;
        i_d   = i_q;
        j_d   = j_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xr_d  = x;
                    yr_d  = y;
                    acc_d = '0;
                    cnt_d = '0;
                    i_d   = '0;
                    j_d   = '0;
                end
            end
            BUSY: begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
                if (i_q == IDX_W'(D - 1)) begin
                    i_d = '0;
                    j_d = j_q + 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
                // The final partial product lands straight in z, not via acc.
                if (last_pair) begin
                    z_d = sum;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == BUSY);
        done = (state_q == DONE);
        z    = z_q;
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed plus randomized bench for seq_multiplier; expected products come from plain x*y.
module tb_seq_multiplier;

    localparam int W  = 8;
    localparam int NP = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           busy;
    logic           done;
    logic [2*W-1:0] z;

    int tests = 0;
    int fails = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .z     (z)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction observed over 20 cycles after the accepting edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        logic [2*W-1:0] exp_z;
        logic [2*W-1:0] prev_z;
        logic [2*W-1:0] z_done;
        int busy_n, done_n, done_k, overlap, zmove;
        exp_z   = (2*W)'(a) * (2*W)'(b);
        busy_n  = 0;
        done_n  = 0;
        done_k  = -1;
        overlap = 0;
        zmove   = 0;
        z_done  = '0;
        @(negedge clk);
        prev_z = z;
        start  = 1'b1;
        x      = a;
        y      = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = W'($urandom);
        y     = W'($urandom);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_n++;
                done_k = k;
                z_done = z;
            end
            if (busy === 1'b1 && done === 1'b1) overlap++;
            if (done !== 1'b1 && done_n == 0 && z !== prev_z) zmove++;
            if (inject && k == 3) begin
                start = 1'b1;
                x     = 8'd1;
                y     = 8'd1;
            end
            if (inject && k == 4) start = 1'b0;
        end
        check("busy_cycles", busy_n, NP);
        check("done_pulses", done_n, 1);
        check("done_latency", done_k, NP);
        check("product", z_done, exp_z);
        check("busy_done_overlap", overlap, 0);
        check("z_held_while_busy", zmove, 0);
        check("z_held_after_done", z, exp_z);
        $display("[TB] op x=%0d y=%0d z=%0d expected=%0d", a, b, z_done, exp_z);
    endtask

    initial begin
        int dn, mism;
        bit want;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_z", z, 0);
        rst = 1'b0;

        run_op(8'd3, 8'd5, 1'b0);
        run_op(8'd255, 8'd255, 1'b0);
        run_op(8'd0, 8'd200, 1'b0);
        run_op(8'd200, 8'd0, 1'b0);
        run_op(8'd12, 8'd10, 1'b1);

        // Reset during the seventh BUSY cycle discards the partial product.
        @(negedge clk);
        start = 1'b1;
        x     = 8'd100;
        y     = 8'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_busy_before_rst", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_busy", busy, 0);
        check("after_rst_done", done, 0);
        check("after_rst_z", z, 0);
        @(negedge clk);
        check("after_rst_idle", busy, 0);
        $display("[TB] op reset mid-operation x=100 y=100 z=%0d", z);
        run_op(8'd7, 8'd9, 1'b0);

        // Start held high: one accept every NP+2 cycles.
        @(negedge clk);
        start = 1'b1;
        x     = 8'd16;
        y     = 8'd17;
        @(posedge clk);
        dn   = 0;
        mism = 0;
        for (int k = 0; k < 56; k++) begin
            @(negedge clk);
            want = (k == NP) || (k == NP + NP + 2) || (k == NP + 2 * (NP + 2));
            if (done !== want) mism++;
            if (done === 1'b1) begin
                dn++;
                check("b2b_product", z, 272);
                $display("[TB] op back-to-back x=16 y=17 z=%0d at cycle %0d", z, k);
            end
        end
        check("b2b_done_count", dn, 3);
        check("b2b_done_timing", mism, 0);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("b2b_final_z", z, 272);

        for (int n = 0; n < 10; n++) begin
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
